// File: rtl/search_module.sv
// search_module
// Searches for an LFSR tap set. Candidates are tried in descending order, and a
// candidate passes when its Fibonacci LFSR, seeded with 1, does not come back
// to 1 (or fall to 0) within WINDOW shifts.
//
// Ports
//   clk      system clock, rising edge
//   ext_res  asynchronous active-low reset
//   start    level request, sampled only while idle
//   found    a passing tap set has been found (held until reset)
//   started  a search is running, or has finished with success
//   co_buf   tap set under test / passing tap set, tap[k] in bits [8k+7:8k]
//
// state | meaning
// IDLE  | waiting for start; also where an exhausted search returns
// LOAD  | publish candidate on co_buf, seed LFSR with 1, clear shift counter
// RUN   | shift LFSR once per cycle until it fails or survives WINDOW shifts
// NEXT  | step to the following candidate, or give up when none is left
// DONE  | passing candidate held on co_buf until reset
module search_module #(
   parameter int NUM_OF_TAPS = 16,
   parameter int SIZE        = 32,
   parameter int WINDOW      = 256
) (
   input  logic                     clk,
   input  logic                     ext_res,
   input  logic                     start,
   output logic                     found,
   output logic                     started,
   output logic [NUM_OF_TAPS*8-1:0] co_buf
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_NEXT, S_DONE} state_t;

   state_t          state;
   state_t          state_nxt;

   logic [7:0]      tap       [NUM_OF_TAPS];
   logic [7:0]      tap_first [NUM_OF_TAPS];
   logic [7:0]      tap_nxt   [NUM_OF_TAPS];
   logic [SIZE-1:0] lfsr;
   logic [SIZE-1:0] lfsr_shift;
   logic [15:0]     cnt;
   logic            feedback;
   logic            tap_hit;
   logic            run_fail;
   logic            run_pass;
   logic            exhausted;
   logic [7:0]      piv_val;
   int              piv_idx;

   always_comb begin
      for (int k = 0; k < NUM_OF_TAPS; k++)
         tap_first[k] = 8'(SIZE - 1 - k);
   end

   // Feedback scans bit positions rather than indexing the LFSR with the tap
   // value, so the 8-bit tap registers never address past SIZE-1.
   always_comb begin
      feedback = 1'b0;
      tap_hit  = 1'b0;
      for (int b = 0; b < SIZE; b++) begin
         tap_hit = 1'b0;
         for (int k = 0; k < NUM_OF_TAPS; k++)
            if (tap[k] == 8'(b))
               tap_hit = 1'b1;
         feedback = feedback ^ (tap_hit & lfsr[b]);
      end
   end

   assign lfsr_shift = {lfsr[SIZE-2:0], feedback};
   assign run_fail   = (lfsr_shift == '0) || (lfsr_shift == SIZE'(1));
   assign run_pass   = (cnt == 16'(WINDOW - 1));

   // Successor: the right-most tap that still has room to move down is the
   // pivot; it steps down by one and every tap after it packs directly below.
   always_comb begin
      exhausted = 1'b1;
      piv_idx   = 0;
      piv_val   = '0;
      for (int i = 1; i < NUM_OF_TAPS; i++) begin
         if (tap[i] > 8'(NUM_OF_TAPS - 1 - i)) begin
            exhausted = 1'b0;
            piv_idx   = i;
            piv_val   = tap[i];
         end
      end
      for (int j = 0; j < NUM_OF_TAPS; j++) begin
         tap_nxt[j] = tap[j];
         if (!exhausted && (j >= piv_idx))
            tap_nxt[j] = piv_val - 8'(j - piv_idx + 1);
      end
   end

   always_ff @(posedge clk or negedge ext_res) begin
      if (!ext_res)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_RUN;
         S_RUN: begin
            if (run_fail)
               state_nxt = S_NEXT;
            else if (run_pass)
               state_nxt = S_DONE;
         end
         S_NEXT:  state_nxt = exhausted ? S_IDLE : S_LOAD;
         S_DONE:  state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      found   = (state == S_DONE);
      started = (state != S_IDLE);
   end

   always_ff @(posedge clk or negedge ext_res) begin
      if (!ext_res) begin
         for (int k = 0; k < NUM_OF_TAPS; k++)
            tap[k] <= '0;
         co_buf <= '0;
         lfsr   <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start)
                  for (int k = 0; k < NUM_OF_TAPS; k++)
                     tap[k] <= tap_first[k];
            end
            S_LOAD: begin
               for (int k = 0; k < NUM_OF_TAPS; k++)
                  co_buf[8*k +: 8] <= tap[k];
               lfsr <= SIZE'(1);
               cnt  <= '0;
            end
            S_RUN: begin
               lfsr <= lfsr_shift;
               cnt  <= cnt + 16'd1;
            end
            S_NEXT: begin
               // on exhaustion tap keeps the last tested set, as co_buf does
               if (!exhausted)
                  for (int k = 0; k < NUM_OF_TAPS; k++)
                     tap[k] <= tap_nxt[k];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_search_module.sv
module tb_search_module;

   logic         clk = 1'b0;
   logic         ext_res;
   logic         start_v   [5];
   logic         found_v   [5];
   logic         started_v [5];
   logic [127:0] co_v      [5];
   logic [127:0] co_def;
   logic [15:0]  co_a;
   logic [15:0]  co_b;
   logic [23:0]  co_c;
   logic [31:0]  co_d;

   int total = 0;
   int bad   = 0;

   // instance index -> configuration (index 0 is the default-parameter DUT)
   int cfg_size [5] = '{32, 4, 4, 6, 7};
   int cfg_taps [5] = '{16, 2, 2, 3, 4};

   typedef struct {
      int           idx;
      bit           pass;
      logic [127:0] co;
      int           t_end;   // edges after the start edge until DONE/IDLE
   } vec_t;

   vec_t vec [4];

   always #5 clk = ~clk;

   search_module u_def (
      .clk(clk), .ext_res(ext_res), .start(start_v[0]),
      .found(found_v[0]), .started(started_v[0]), .co_buf(co_def));

   search_module #(.NUM_OF_TAPS(2), .SIZE(4), .WINDOW(14)) u_a (
      .clk(clk), .ext_res(ext_res), .start(start_v[1]),
      .found(found_v[1]), .started(started_v[1]), .co_buf(co_a));

   search_module #(.NUM_OF_TAPS(2), .SIZE(4), .WINDOW(16)) u_b (
      .clk(clk), .ext_res(ext_res), .start(start_v[2]),
      .found(found_v[2]), .started(started_v[2]), .co_buf(co_b));

   search_module #(.NUM_OF_TAPS(3), .SIZE(6), .WINDOW(63)) u_c (
      .clk(clk), .ext_res(ext_res), .start(start_v[3]),
      .found(found_v[3]), .started(started_v[3]), .co_buf(co_c));

   search_module #(.NUM_OF_TAPS(4), .SIZE(7), .WINDOW(100)) u_d (
      .clk(clk), .ext_res(ext_res), .start(start_v[4]),
      .found(found_v[4]), .started(started_v[4]), .co_buf(co_d));

   assign co_v[0] = co_def;
   assign co_v[1] = {112'd0, co_a};
   assign co_v[2] = {112'd0, co_b};
   assign co_v[3] = {104'd0, co_c};
   assign co_v[4] = {96'd0, co_d};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: candidate sets are bitmasks with bit SIZE-1 set and NTAPS bits
   // set; descending numeric mask order is the required candidate order.
   function automatic void model(input int size, input int ntaps, input int window,
                                 output logic [127:0] co, output bit pass, output int t_end);
      int  k;
      int  st;
      int  s;
      bit  failed;
      co    = '0;
      pass  = 1'b0;
      t_end = 0;
      for (int m = (1 << size) - 1; m > 0; m--) begin
         if ((((m >> (size - 1)) & 1) == 0) || ($countones(m) != ntaps))
            continue;
         co = '0;
         k  = 0;
         for (int b = size - 1; b >= 0; b--)
            if (((m >> b) & 1) == 1) begin
               co[8*k +: 8] = 8'(b);
               k++;
            end
         st     = 1;
         failed = 1'b0;
         for (s = 1; s <= window; s++) begin
            st = ((st << 1) | ($countones(st & m) & 1)) & ((1 << size) - 1);
            if (st <= 1) begin
               failed = 1'b1;
               break;
            end
         end
         if (!failed) begin
            pass  = 1'b1;
            t_end = t_end + window + 1;
            return;
         end
         t_end = t_end + s + 2;
      end
   endfunction

   function automatic logic [127:0] first_co(input int idx);
      logic [127:0] r = '0;
      for (int k = 0; k < cfg_taps[idx]; k++)
         r[8*k +: 8] = 8'(cfg_size[idx] - 1 - k);
      return r;
   endfunction

   // called at #1 after a rising edge; reset is released well before the next one
   task automatic pulse_reset();
      ext_res = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("async_rst started dut%0d", i), 128'(started_v[i]), 128'd0);
         chk($sformatf("async_rst found dut%0d", i), 128'(found_v[i]), 128'd0);
         chk($sformatf("async_rst co_buf dut%0d", i), co_v[i], 128'd0);
      end
      ext_res = 1'b1;
   endtask

   // sticky: DUTs whose candidate passes are already in DONE and get random start
   task automatic run_search(input int plen, input bit use_def, input int rst_at, input bit sticky);
      int t_max;
      int i;
      int t;
      bit hold;
      bit exp_on;
      bit exp_fd;
      t_max = 0;
      foreach (vec[v])
         if (vec[v].t_end > t_max) t_max = vec[v].t_end;
      start_v[0] = use_def;
      for (int n = 1; n < 5; n++) start_v[n] = 1'b1;
      for (int e = 0; e <= t_max + 2; e++) begin
         @(posedge clk);
         #1;
         if (e == rst_at) begin
            pulse_reset();
            for (int n = 0; n < 5; n++) start_v[n] = 1'b0;
            return;
         end
         if (use_def && e == 0)
            chk("def started", 128'(started_v[0]), 128'd1);
         if (use_def && e == 1)
            chk("def first co_buf", co_v[0], 128'h101112131415161718191A1B1C1D1E1F);
         foreach (vec[v]) begin
            i      = vec[v].idx;
            t      = vec[v].t_end;
            hold   = sticky && vec[v].pass;
            exp_on = hold ? 1'b1 : ((e < t) ? 1'b1 : vec[v].pass);
            exp_fd = hold ? 1'b1 : ((e < t) ? 1'b0 : vec[v].pass);
            chk($sformatf("started dut%0d e=%0d", i, e), 128'(started_v[i]), 128'(exp_on));
            chk($sformatf("found dut%0d e=%0d", i, e), 128'(found_v[i]), 128'(exp_fd));
            if (hold || e == t)
               chk($sformatf("final co_buf dut%0d e=%0d", i, e), co_v[i], vec[v].co);
            else if (e == 1)
               chk($sformatf("first co_buf dut%0d", i), co_v[i], first_co(i));
            if (hold)
               start_v[i] = 1'($urandom_range(0, 1));
            else
               start_v[i] = (e + 1 < plen);
         end
         start_v[0] = use_def && (e + 1 < plen);
      end
      for (int n = 0; n < 5; n++) start_v[n] = 1'b0;
   endtask

   initial begin
      logic [127:0] co;
      bit           p;
      int           t;
      int           rst_at;

      ext_res = 1'b0;
      for (int n = 0; n < 5; n++) start_v[n] = 1'b1;

      // held in reset with clock running and start high
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         for (int n = 0; n < 5; n++) begin
            chk($sformatf("in_rst started dut%0d", n), 128'(started_v[n]), 128'd0);
            chk($sformatf("in_rst found dut%0d", n), 128'(found_v[n]), 128'd0);
            chk($sformatf("in_rst co_buf dut%0d", n), co_v[n], 128'd0);
         end
      end
      for (int n = 0; n < 5; n++) start_v[n] = 1'b0;
      ext_res = 1'b1;

      // (3,2) is maximal length, (3,1) returns to 1 after 6 shifts, (3,0) after 15
      vec[0] = '{1, 1'b1, 128'h0203, 15};
      vec[1] = '{2, 1'b0, 128'h0003, 17 + 8 + 17};
      model(6, 3, 63, co, p, t);
      vec[2] = '{3, p, co, t};
      model(7, 4, 100, co, p, t);
      vec[3] = '{4, p, co, t};

      @(posedge clk);
      #1;
      run_search(2, 1'b1, -1, 1'b0);
      // exhausted DUTs restart from IDLE; DONE DUTs ignore random start
      run_search($urandom_range(1, 4), 1'b0, -1, 1'b1);

      for (int it = 0; it < 5; it++) begin
         @(posedge clk);
         #1;
         pulse_reset();
         for (int g = $urandom_range(0, 5); g > 0; g--) @(posedge clk);
         #1;
         rst_at = ($urandom_range(0, 1) == 0) ? int'($urandom_range(2, 12)) : -1;
         run_search($urandom_range(1, 4), 1'b0, rst_at, 1'b0);
         if (rst_at >= 0) begin
            @(posedge clk);
            #1;
            run_search($urandom_range(1, 4), 1'b0, -1, 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
